// File: rtl/flag_unit_pkg.sv
// Shared definitions for the flag unit, the ALU and branch/predication logic:
// flag bit positions, condition codes and the ALU opcode set.
package flag_unit_pkg;

  // Flag bit positions inside every 4-bit flag set and the low nibble of the 32-bit words
  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_O = 0;

  // Branch condition selectors
  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  // ALU opcodes, kept here so the ALU and the flag logic share one definition
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_XOR = 4'h4;
  localparam logic [3:0] ALU_SHL = 4'h5;
  localparam logic [3:0] ALU_SHR = 4'h6;
  localparam logic [3:0] ALU_CMP = 4'h7;

  typedef logic [3:0] flags_t;

  // Assemble individual ALU flag outputs into the fixed N/Z/C/O layout
  function automatic flags_t pack_flags(input logic n, input logic z,
                                        input logic c, input logic o);
    flags_t f;
    f        = '0;
    f[FLG_N] = n;
    f[FLG_Z] = z;
    f[FLG_C] = c;
    f[FLG_O] = o;
    return f;
  endfunction

endpackage

// File: rtl/flag_unit_cond_eval.sv
// Combinational condition decoder: 4-bit condition code + flag set -> taken.
module flag_unit_cond_eval
  import flag_unit_pkg::*;
(
  input  logic [3:0] code,
  input  flags_t     flags,
  output logic       taken
);

  logic n, z, c, o;

  assign n = flags[FLG_N];
  assign z = flags[FLG_Z];
  assign c = flags[FLG_C];
  assign o = flags[FLG_O];

  // Decode the selected condition against the supplied flags
  always_comb begin
    taken = 1'b0;
    case (code)
      COND_EQ: taken = z;
      COND_NE: taken = ~z;
      COND_CS: taken = c;
      COND_CC: taken = ~c;
      COND_MI: taken = n;
      COND_PL: taken = ~n;
      COND_VS: taken = o;
      COND_VC: taken = ~o;
      COND_HI: taken = c & ~z;
      COND_LS: taken = ~c | z;
      COND_GE: taken = (n == o);
      COND_LT: taken = (n != o);
      COND_GT: taken = ~z & (n == o);
      COND_LE: taken = z | (n != o);
      COND_AL: taken = 1'b1;
      COND_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_unit.sv
// Architectural flag register with condition evaluation and a small LIFO
// of saved flag sets used for interrupt/call save-restore.
module flag_unit
  import flag_unit_pkg::*;
#(
  parameter int STACK_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  input  logic        alu_carry,
  input  logic        alu_negative,
  input  logic        flag_we,
  input  logic        push,
  input  logic        pop,
  input  logic        cond_valid,
  input  logic [3:0]  cond_code,
  output logic        cond_done,
  output logic        cond_taken,
  output logic [31:0] flags_word,
  output logic [31:0] restore_word,
  output logic        restore_strobe,
  output logic        stack_full,
  output logic        stack_empty,
  output logic        stack_err
);

  // Count needs one extra bit so that "full" (== STACK_DEPTH) is representable
  localparam int PTR_W = $clog2(STACK_DEPTH) + 1;
  localparam int IDX_W = PTR_W - 1;

  flags_t            flags_reg;
  flags_t            restore_reg;
  flags_t            stack_mem [STACK_DEPTH];
  logic [PTR_W-1:0]  count_reg;
  logic              err_reg;
  logic              strobe_reg;
  logic              done_reg;
  logic              taken_reg;

  flags_t            alu_flags;
  flags_t            popped;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  pop_idx;
  logic              full, empty;
  logic              do_push, do_pop, err_set;
  logic              eval_taken;

  assign alu_flags = pack_flags(alu_negative, alu_zero, alu_carry, alu_overflow);

  assign full  = (count_reg == PTR_W'(STACK_DEPTH));
  assign empty = (count_reg == '0);

  assign push_idx = count_reg[IDX_W-1:0];
  assign pop_idx  = IDX_W'(count_reg - PTR_W'(1));
  assign popped   = stack_mem[pop_idx];

  // A simultaneous push and pop cancels both and is reported as an error
  assign do_push = push & ~pop & ~full;
  assign do_pop  = pop & ~push & ~empty;
  assign err_set = (push & pop) | (push & ~pop & full) | (pop & ~push & empty);

  flag_unit_cond_eval u_cond_eval (
    .code  (cond_code),
    .flags (flags_reg),
    .taken (eval_taken)
  );

  // Stack storage: contents are don't-care after reset, so no reset term
  always_ff @(posedge clk) begin
    if (do_push) stack_mem[push_idx] <= flags_reg;
  end

  // Flag register, stack pointer, restore word/strobe and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_reg   <= '0;
      restore_reg <= '0;
      count_reg   <= '0;
      err_reg     <= 1'b0;
      strobe_reg  <= 1'b0;
    end else begin
      strobe_reg <= do_pop;
      if (do_pop) begin
        flags_reg   <= popped;
        restore_reg <= popped;
      end else if (flag_we) begin
        flags_reg <= alu_flags;
      end
      if (do_push)     count_reg <= count_reg + PTR_W'(1);
      else if (do_pop) count_reg <= count_reg - PTR_W'(1);
      if (err_set) err_reg <= 1'b1;
    end
  end

  // One-cycle condition evaluation against the flags held before this edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_reg  <= 1'b0;
      taken_reg <= 1'b0;
    end else begin
      done_reg <= cond_valid;
      if (cond_valid) taken_reg <= eval_taken;
    end
  end

  assign cond_done      = done_reg;
  assign cond_taken     = taken_reg;
  assign flags_word     = {28'b0, flags_reg};
  assign restore_word   = {28'b0, restore_reg};
  assign restore_strobe = strobe_reg;
  assign stack_full     = full;
  assign stack_empty    = empty;
  assign stack_err      = err_reg;

endmodule

// File: tb/tb_flag_unit.sv
// Directed testbench for flag_unit: reset, capture/evaluate, stack round trip,
// error cases, simultaneous commands and a full condition-code sweep.
module tb_flag_unit;

  logic        clk;
  logic        rst_n;
  logic        alu_zero, alu_overflow, alu_carry, alu_negative;
  logic        flag_we, push, pop, cond_valid;
  logic [3:0]  cond_code;
  logic        cond_done, cond_taken;
  logic [31:0] flags_word, restore_word;
  logic        restore_strobe, stack_full, stack_empty, stack_err;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Hand-derived truth table: bit f of entry c is the result of code c on flags f (NZCO)
  logic [15:0] cond_mask [16] = '{
    16'hF0F0, 16'h0F0F, 16'hCCCC, 16'h3333,
    16'hFF00, 16'h00FF, 16'hAAAA, 16'h5555,
    16'h0C0C, 16'hF3F3, 16'hAA55, 16'h55AA,
    16'h0A05, 16'hF5FA, 16'hFFFF, 16'h0000
  };
  logic [3:0] pop_exp [4] = '{4'h8, 4'h4, 4'h2, 4'h1};

  flag_unit #(.STACK_DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .alu_zero       (alu_zero),
    .alu_overflow   (alu_overflow),
    .alu_carry      (alu_carry),
    .alu_negative   (alu_negative),
    .flag_we        (flag_we),
    .push           (push),
    .pop            (pop),
    .cond_valid     (cond_valid),
    .cond_code      (cond_code),
    .cond_done      (cond_done),
    .cond_taken     (cond_taken),
    .flags_word     (flags_word),
    .restore_word   (restore_word),
    .restore_strobe (restore_strobe),
    .stack_full     (stack_full),
    .stack_empty    (stack_empty),
    .stack_err      (stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flag_we    = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    cond_valid = 1'b0;
  endtask

  task automatic set_alu(input logic [3:0] f);
    alu_negative = f[3];
    alu_zero     = f[2];
    alu_carry    = f[1];
    alu_overflow = f[0];
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
    $display("vec %0d %s observed %h required %h", vec_cnt, tag, obs, exp);
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %b required %b", tag, obs, exp);
    end
    $display("vec %0d %s observed %b required %b", vec_cnt, tag, obs, exp);
  endtask

  initial begin
    idle();
    set_alu(4'h0);
    cond_code = 4'h0;
    rst_n     = 1'b0;

    // Reset held while commands are active
    push    = 1'b1;
    flag_we = 1'b1;
    set_alu(4'hF);
    tick();
    tick();
    idle();
    set_alu(4'h0);
    rst_n = 1'b1;
    tick();
    check32("rst_flags", flags_word, 32'h0);
    check1("rst_empty", stack_empty, 1'b1);
    check1("rst_full", stack_full, 1'b0);
    check1("rst_err", stack_err, 1'b0);
    check1("rst_done", cond_done, 1'b0);
    check1("rst_strobe", restore_strobe, 1'b0);
    check32("rst_restore", restore_word, 32'h0);

    // Capture N=1 Z=0 C=1 O=0 and evaluate GE, LT, HI back to back
    set_alu(4'hA);
    flag_we = 1'b1;
    tick();
    idle();
    check32("cap_flags", flags_word, 32'h0000_000A);
    cond_valid = 1'b1;
    cond_code  = 4'd10;
    tick();
    check1("ge_done", cond_done, 1'b1);
    check1("ge_taken", cond_taken, 1'b0);
    cond_code = 4'd11;
    tick();
    check1("lt_done", cond_done, 1'b1);
    check1("lt_taken", cond_taken, 1'b1);
    cond_code = 4'd8;
    tick();
    check1("hi_taken", cond_taken, 1'b1);
    idle();
    tick();
    check1("idle_done", cond_done, 1'b0);
    check1("idle_hold", cond_taken, 1'b1);

    // EQ evaluated on the same edge Z is being set sees the old Z=0
    set_alu(4'h4);
    flag_we    = 1'b1;
    cond_valid = 1'b1;
    cond_code  = 4'd0;
    tick();
    flag_we = 1'b0;
    check1("eq_pre_update", cond_taken, 1'b0);
    check32("eq_flags", flags_word, 32'h4);
    tick();
    check1("eq_post_update", cond_taken, 1'b1);
    idle();

    // Stack fill: push saves old flags while flag_we loads the next value
    set_alu(4'h1);
    flag_we = 1'b1;
    tick();
    push = 1'b1;
    set_alu(4'h2);
    tick();
    set_alu(4'h4);
    tick();
    set_alu(4'h8);
    tick();
    flag_we = 1'b0;
    tick();
    idle();
    check1("fill_full", stack_full, 1'b1);
    check1("fill_err", stack_err, 1'b0);
    check32("fill_flags", flags_word, 32'h8);

    // Overflow
    push = 1'b1;
    tick();
    idle();
    check1("ovf_err", stack_err, 1'b1);
    check1("ovf_full", stack_full, 1'b1);

    // Drain: each pop restores the most recent save with a single-cycle strobe
    for (int i = 0; i < 4; i++) begin
      pop = 1'b1;
      tick();
      pop = 1'b0;
      check1("pop_strobe", restore_strobe, 1'b1);
      check32("pop_restore", restore_word, {28'b0, pop_exp[i]});
      check32("pop_flags", flags_word, {28'b0, pop_exp[i]});
      tick();
      check1("pop_strobe_low", restore_strobe, 1'b0);
    end
    check1("drain_empty", stack_empty, 1'b1);
    check32("drain_flags", flags_word, 32'h1);

    // Push and pop together: both cancelled, flag_we still applies
    do_reset();
    check1("rst2_err", stack_err, 1'b0);
    set_alu(4'h3);
    flag_we = 1'b1;
    tick();
    idle();
    push = 1'b1;
    tick();
    idle();
    check1("one_empty", stack_empty, 1'b0);
    push    = 1'b1;
    pop     = 1'b1;
    flag_we = 1'b1;
    set_alu(4'h5);
    tick();
    idle();
    check1("pp_empty", stack_empty, 1'b0);
    check1("pp_strobe", restore_strobe, 1'b0);
    check1("pp_err", stack_err, 1'b1);
    check32("pp_flags", flags_word, 32'h5);
    pop = 1'b1;
    tick();
    idle();
    check32("pp_count_restore", restore_word, 32'h3);
    check1("pp_count_empty", stack_empty, 1'b1);

    // Valid pop wins over flag_we
    set_alu(4'h6);
    flag_we = 1'b1;
    tick();
    idle();
    push = 1'b1;
    tick();
    idle();
    set_alu(4'h9);
    flag_we = 1'b1;
    tick();
    check32("pre_pop_flags", flags_word, 32'h9);
    set_alu(4'hF);
    pop = 1'b1;
    tick();
    idle();
    check32("popwe_flags", flags_word, 32'h6);
    check32("popwe_restore", restore_word, 32'h6);

    // Underflow from empty
    do_reset();
    set_alu(4'h5);
    flag_we = 1'b1;
    tick();
    idle();
    pop = 1'b1;
    tick();
    idle();
    check1("unf_strobe", restore_strobe, 1'b0);
    check1("unf_err", stack_err, 1'b1);
    check32("unf_flags", flags_word, 32'h5);
    check1("unf_empty", stack_empty, 1'b1);

    // Every condition code against every flag combination
    for (int f = 0; f < 16; f++) begin
      set_alu(4'(f));
      flag_we = 1'b1;
      tick();
      flag_we = 1'b0;
      for (int c = 0; c < 16; c++) begin
        cond_valid = 1'b1;
        cond_code  = 4'(c);
        tick();
        check1($sformatf("sweep_c%0d_f%0h", c, f), cond_taken, cond_mask[c][f]);
      end
      idle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
